// File: rtl/xm_wb_timer_pkg.sv
// xm_wb_timer_pkg: register map, bit positions and helpers for the Wishbone timer
package xm_wb_timer_pkg;
   localparam int REG_W = 16;
   typedef enum logic [2:0] {
      IDX_CTRL     = 3'd0,
      IDX_STATUS   = 3'd1,
      IDX_RELOAD   = 3'd2,
      IDX_COUNT    = 3'd3,
      IDX_PRESCALE = 3'd4
   } reg_idx_e;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_AUTO  = 1;
   localparam int CTRL_IRQEN = 2;
   localparam int STATUS_EXP = 0;
   function automatic logic [REG_W-1:0] byte_merge(input logic [REG_W-1:0] old_v,
                                                   input logic [REG_W-1:0] new_v,
                                                   input logic [1:0] sel);
      return {sel[1] ? new_v[REG_W-1:REG_W/2] : old_v[REG_W-1:REG_W/2],
              sel[0] ? new_v[REG_W/2-1:0]     : old_v[REG_W/2-1:0]};
   endfunction
endpackage

// File: rtl/xm_prescaler.sv
// xm_prescaler: counts 0..limit while enabled and pulses o_tick on the terminal count
module xm_prescaler
   import xm_wb_timer_pkg::*;
(
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             i_en,
   input  logic [REG_W-1:0] i_limit,
   output logic             o_tick
);
   logic [REG_W-1:0] r_cnt;
   assign o_tick = i_en & (r_cnt == i_limit);
   // held at zero while disabled, so enabling always starts a fresh period
   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) r_cnt <= '0;
      else          r_cnt <= (!i_en || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/xm_wb_timer.sv
// xm_wb_timer: Wishbone classic down-counting timer with prescaler, auto-reload and interrupt
module xm_wb_timer
   import xm_wb_timer_pkg::*;
#(
   parameter logic [14:0] BASE_ADR = 15'h7F00
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             we_i,
   input  logic             stb_i,
   input  logic             cyc_i,
   input  logic [1:0]       sel_i,
   input  logic [14:0]      adr_i,
   input  logic [REG_W-1:0] dat_i,
   output logic             ack_o,
   output logic [REG_W-1:0] dat_o,
   output logic             irq_o
);
   logic             r_ack;
   logic [REG_W-1:0] r_dat;
   logic [2:0]       r_ctrl;
   logic             r_exp;
   logic [REG_W-1:0] r_reload;
   logic [REG_W-1:0] r_count;
   logic [REG_W-1:0] r_presc;
   logic             w_hit, w_acc, w_wr, w_tick, w_expire;
   logic             w_wr_ctrl, w_wr_status, w_wr_reload, w_wr_count, w_wr_presc;
   logic [REG_W-1:0] w_rdata;
   assign w_hit       = cyc_i & stb_i & (adr_i[14:3] == BASE_ADR[14:3]);
   assign w_acc       = w_hit & ~r_ack;
   assign w_wr        = w_acc & we_i;
   assign w_wr_ctrl   = w_wr & (adr_i[2:0] == IDX_CTRL);
   assign w_wr_status = w_wr & (adr_i[2:0] == IDX_STATUS);
   assign w_wr_reload = w_wr & (adr_i[2:0] == IDX_RELOAD);
   assign w_wr_count  = w_wr & (adr_i[2:0] == IDX_COUNT);
   assign w_wr_presc  = w_wr & (adr_i[2:0] == IDX_PRESCALE);
   assign w_expire    = w_tick & (r_count == '0);
   assign ack_o       = r_ack;
   assign dat_o       = r_dat;
   assign irq_o       = r_exp & r_ctrl[CTRL_IRQEN];
   xm_prescaler u_prescaler (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .i_en    (r_ctrl[CTRL_EN]),
      .i_limit (r_presc),
      .o_tick  (w_tick)
   );
   always_comb begin
      w_rdata = (adr_i[2:0] == IDX_CTRL)     ? {{(REG_W-3){1'b0}}, r_ctrl} :
                (adr_i[2:0] == IDX_STATUS)   ? {{(REG_W-1){1'b0}}, r_exp}  :
                (adr_i[2:0] == IDX_RELOAD)   ? r_reload :
                (adr_i[2:0] == IDX_COUNT)    ? r_count  :
                (adr_i[2:0] == IDX_PRESCALE) ? r_presc  : '0;
   end
   // bus writes take priority over the tick; a new expiry beats a same-cycle W1C
   always_ff @(posedge clk_i or negedge arst_ni)
      if (!arst_ni) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_ctrl   <= '0;
         r_exp    <= 1'b0;
         r_reload <= '0;
         r_count  <= '0;
         r_presc  <= '0;
      end else begin
         r_ack <= w_acc;
         r_dat <= w_acc ? w_rdata : '0;
         if (w_wr_ctrl && sel_i[0]) r_ctrl <= dat_i[2:0];
         else if (w_expire && !r_ctrl[CTRL_AUTO]) r_ctrl[CTRL_EN] <= 1'b0;
         r_exp <= w_expire | (r_exp & ~(w_wr_status & sel_i[0] & dat_i[STATUS_EXP]));
         if (w_wr_reload) r_reload <= byte_merge(r_reload, dat_i, sel_i);
         if (w_wr_presc)  r_presc  <= byte_merge(r_presc, dat_i, sel_i);
         if (w_wr_count && sel_i != 2'b00) r_count <= byte_merge(r_count, dat_i, sel_i);
         else if (w_tick) r_count <= (r_count != '0) ? r_count - 1'b1 :
                                     (r_ctrl[CTRL_AUTO] ? r_reload : '0);
      end
endmodule

// File: doc/xm_wb_timer.md
XM_WB_TIMER -- requirements
Module: xm_wb_timer

Interface
REQ-001 SHALL have parameter BASE_ADR, 15'h7F00, word address of register block (bits [2:0] ignored).
REQ-002 SHALL have port clk_i  input  1  single system clock; all logic rising-edge.
REQ-003 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports we_i, stb_i, cyc_i  input  1 each  Wishbone classic responder controls.
REQ-005 SHALL have port sel_i  input  2  byte lanes: sel_i[0] = dat[7:0], sel_i[1] = dat[15:8].
REQ-006 SHALL have port adr_i  input  15  word address.
REQ-007 SHALL have port dat_i  input  16  write data.
REQ-008 SHALL have port ack_o  output  1  transfer acknowledge.
REQ-009 SHALL have port dat_o  output  16  read data.
REQ-010 SHALL have port irq_o  output  1  level interrupt, expired & irq enable.

Function
REQ-011 SHALL decode hit = cyc_i & stb_i & (adr_i[14:3] == BASE_ADR[14:3]); index = adr_i[2:0].
REQ-012 SHALL register ack_o <= hit & ~ack_o: one wait state; ack_o high exactly one cycle per access; back-to-back accesses alternate ack low/high.
REQ-013 SHALL not assert ack_o for non-hit cycles; cyc_i/stb_i dropping before ack cancels the access without side effects.
REQ-014 SHALL commit writes on the edge at which ack_o rises, per byte lane enabled in sel_i; sel_i = 2'b00 writes nothing but still acks.
REQ-015 SHALL register dat_o on the same edge; dat_o valid while ack_o high, 16'h0000 otherwise; reads ignore sel_i.
REQ-016 SHALL map: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IRQEN, others read 0); 1 STATUS (bit0 EXP, write-1-to-clear); 2 RELOAD (rw); 3 COUNT (read current; write loads); 4 PRESCALE (rw); 5-7 read 0, writes ignored, acked.
REQ-017 SHALL, while EN, count prescaler 0..PRESCALE and emit one tick when prescaler == PRESCALE, then return to 0; PRESCALE = 0 ticks every cycle.
REQ-018 SHALL on tick: COUNT != 0 -> COUNT-1; COUNT == 0 -> set EXP, then AUTO ? COUNT <= RELOAD : clear EN.
REQ-019 SHALL hold prescaler at 0 while EN low; writing CTRL.EN 0->1 restarts prescaler at 0.
REQ-020 SHALL give bus write priority over tick for COUNT and CTRL.EN in the same cycle.
REQ-021 SHALL give EXP set priority over W1C clear in the same cycle.
REQ-022 SHALL drive irq_o = EXP & IRQEN combinationally from registers.

Reset
REQ-023 SHALL on arst_ni low, immediately: ack_o 0, dat_o 0, CTRL 0, STATUS 0, RELOAD 0, COUNT 0, PRESCALE 0, prescaler 0, irq_o 0.
REQ-024 SHALL abort any in-flight access on reset; first access after release acks normally.

Structure
REQ-025 SHALL place register index enum (CTRL..PRESCALE), CTRL/STATUS bit positions, and register width in package xm_wb_timer_pkg.
REQ-026 SHALL implement tick generation as sub-module xm_prescaler (enable, limit in, tick out, async active-low reset).

Verification
REQ-027 Reset mid-access: assert arst_ni low while stb/cyc high -> ack_o 0 same time, all reads afterward return 0.
REQ-028 Write RELOAD=16'h0003, COUNT=16'h0003, PRESCALE=0, CTRL=16'h0007 -> COUNT reads 2,1,0 on successive ticks, EXP=1 and irq_o=1 on 4th tick, COUNT reloads to 3.
REQ-029 Byte write sel=2'b10 dat=16'hABCD to RELOAD holding 16'h1234 -> RELOAD reads 16'hAB34.
REQ-030 One-shot: CTRL=16'h0001, COUNT=1, PRESCALE=2 -> tick every 3 cycles, EXP after 2 ticks, CTRL reads 0, COUNT stays 0.
REQ-031 W1C STATUS=16'h0001 coincident with expiry tick -> EXP remains 1; W1C later -> EXP 0, irq_o 0.
REQ-032 Access to adr 15'h7F05 -> ack after one wait state, dat_o 0; access to 15'h7E00 -> no ack for 10 cycles.
